// File: rtl/multisim_client_quasi_static_pull.sv
// Client-side quasi-static value receiver: pulls updates over a multisim channel, buffers them,
// and replays them on a held bus with a minimum hold time. Optional: MULTISIM_QS_DUP_FILTER_EN.

package multisim_chan_pkg;
  localparam int NCH = 4;
  logic [63:0] chan      [NCH][$];
  string       chan_name [NCH];

  function automatic int chan_idx(input string n);
    int r;
    r = 0;
    for (int i = 0; i < NCH; i++)
      if (chan_name[i] == n) r = i;
    return r;
  endfunction

  function automatic bit chan_has(input string n, input int unsigned i);
    return int'(i) < chan[chan_idx(n)].size();
  endfunction

  function automatic logic [63:0] chan_peek(input string n, input int unsigned i);
    int c;
    c = chan_idx(n);
    return (int'(i) < chan[c].size()) ? chan[c][i] : 64'd0;
  endfunction
endpackage

// Channel endpoint: offers entries in order; an offer only becomes visible while data_rdy is high.
module multisim_client_pull #(
  parameter int DATA_WIDTH = 64
)(
  input  logic                  clk,
  input  string                 server_name,
  input  logic                  data_rdy,
  output logic                  data_vld,
  output logic [DATA_WIDTH-1:0] data
);
  int unsigned           rd_q, rd_d;
  bit                    vld_q;
  logic [DATA_WIDTH-1:0] data_q;

  always_comb rd_d = rd_q + 32'(data_vld);

  always_ff @(posedge clk) begin
    rd_q   <= rd_d;
    vld_q  <= multisim_chan_pkg::chan_has(server_name, rd_d);
    data_q <= DATA_WIDTH'(multisim_chan_pkg::chan_peek(server_name, rd_d));
  end

  assign data_vld = vld_q && data_rdy;
  assign data     = data_q;
endmodule

module multisim_client_quasi_static_pull #(
  parameter int                    DATA_WIDTH      = 64,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE     = '0,
  parameter int                    FIFO_DEPTH      = 4,
  parameter int                    MIN_HOLD_CYCLES = 0
)(
  input  logic                               clk,
  input  logic                               rst,
  input  string                              server_name,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic                               data_updated,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = (MIN_HOLD_CYCLES > 0) ? $clog2(MIN_HOLD_CYCLES + 1) : 1;

  typedef enum logic {IDLE, HOLD} state_e;

  logic                  data_rdy, data_vld;
  logic [DATA_WIDTH-1:0] data;
  logic                  rdy_en_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d, head;
  logic                  upd_q, upd_d;
  state_e                state_q, state_d;
  logic [CW-1:0]         hold_q, hold_d;
  logic                  push, pop, apply;

  multisim_client_pull #(.DATA_WIDTH(DATA_WIDTH)) u_pull (
    .clk         (clk),
    .server_name (server_name),
    .data_rdy    (data_rdy),
    .data_vld    (data_vld),
    .data        (data)
  );

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // rdy_en_q keeps ready low through the first edge after reset release.
  assign data_rdy = rdy_en_q && !rst && (level_q < LW'(FIFO_DEPTH));
  assign push     = data_rdy && data_vld;
  assign head     = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: if (apply && (MIN_HOLD_CYCLES > 0)) begin
        state_d = HOLD;
        hold_d  = CW'(MIN_HOLD_CYCLES);
      end
      HOLD: begin
        hold_d = hold_q - CW'(1);
        if (hold_q == CW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop = (state_q == IDLE) && (level_q != '0);
`ifdef MULTISIM_QS_DUP_FILTER_EN
    apply = pop && (head != data_out_q);
`else
    apply = pop;
`endif
    data_out_d = apply ? head : data_out_q;
    upd_d      = apply;
  end

  // Level uses the pre-edge count, so a full FIFO refuses a push even on a popping edge.
  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_en_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      data_out_q <= RESET_VALUE;
      upd_q      <= 1'b0;
    end else begin
      rdy_en_q   <= 1'b1;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      data_out_q <= data_out_d;
      upd_q      <= upd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data;
  end

  always @(posedge clk) begin
    if (!rst)
      assert (!(data_vld && !data_rdy))
        else $error("multisim_client_quasi_static_pull: data_vld while not ready, value dropped");
  end

  assign data_out     = data_out_q;
  assign data_updated = upd_q;
  assign fifo_level   = level_q;
endmodule

// File: tb/tb_multisim_client_quasi_static_pull.sv
// Bench for multisim_client_quasi_static_pull: three configurations checked every cycle against a
// queue/timestamp reference model, plus vector table and directed multi-cycle sequences.
module tb_multisim_client_quasi_static_pull;
`ifdef MULTISIM_QS_DUP_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  string nm_a = "qs_a";
  string nm_b = "qs_b";
  string nm_c = "qs_c";
  logic [15:0] dout_a, dout_b, dout_c;
  logic        upd_a, upd_b, upd_c;
  logic [1:0]  lvl_a;
  logic [2:0]  lvl_b, lvl_c;

  always #5 clk = ~clk;

  multisim_client_quasi_static_pull #(.DATA_WIDTH(16), .RESET_VALUE(16'hDEAD),
    .FIFO_DEPTH(3), .MIN_HOLD_CYCLES(2)) u_a (
    .clk(clk), .rst(rst), .server_name(nm_a),
    .data_out(dout_a), .data_updated(upd_a), .fifo_level(lvl_a));
  multisim_client_quasi_static_pull #(.DATA_WIDTH(16), .RESET_VALUE(16'hDEAD),
    .FIFO_DEPTH(4), .MIN_HOLD_CYCLES(0)) u_b (
    .clk(clk), .rst(rst), .server_name(nm_b),
    .data_out(dout_b), .data_updated(upd_b), .fifo_level(lvl_b));
  multisim_client_quasi_static_pull #(.DATA_WIDTH(16), .RESET_VALUE(16'hDEAD),
    .FIFO_DEPTH(4), .MIN_HOLD_CYCLES(10)) u_c (
    .clk(clk), .rst(rst), .server_name(nm_c),
    .data_out(dout_c), .data_updated(upd_c), .fifo_level(lvl_c));

  typedef struct { int cyc; logic [15:0] v; } ev_t;
  typedef struct { bit push; logic [15:0] val; logic [15:0] exp_out; bit exp_upd; int exp_lvl; } vec_t;

  int n_cmp = 0;
  int n_fail = 0;
  int ecyc = 0;
  int dep [3];
  int hld [3];
  // Reference model: channel backlog, accepted-value queue, and time of last visible change.
  logic [15:0] pend  [3][$];
  logic [15:0] mfifo [3][$];
  bit          offered [3];
  bit          en [3];
  logic [15:0] cur [3];
  bit          mupd [3];
  int          last [3];
  ev_t         log_q [3][$];
  vec_t        tbl [12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_rst(input int k);
    mfifo[k].delete();
    cur[k]  = 16'hDEAD;
    mupd[k] = 1'b0;
    last[k] = -1000;
    en[k]   = 1'b0;
  endtask

  task automatic model_update(input int k);
    bit rdy, acc;
    logic [15:0] v;
    if (rst) begin
      model_rst(k);
    end else begin
      rdy = en[k] && (mfifo[k].size() < dep[k]);
      acc = offered[k] && rdy;
      mupd[k] = 1'b0;
      if ((ecyc - last[k] >= hld[k] + 1) && (mfifo[k].size() > 0)) begin
        v = mfifo[k].pop_front();
        if (!(FILT && v == cur[k])) begin
          cur[k]  = v;
          mupd[k] = 1'b1;
          last[k] = ecyc;
        end
      end
      if (acc) mfifo[k].push_back(pend[k].pop_front());
      en[k] = 1'b1;
    end
    offered[k] = pend[k].size() > 0;
  endtask

  task automatic compare_all();
    logic [15:0] d [3];
    logic        u [3];
    int          l [3];
    d[0] = dout_a; d[1] = dout_b; d[2] = dout_c;
    u[0] = upd_a;  u[1] = upd_b;  u[2] = upd_c;
    l[0] = int'(lvl_a); l[1] = int'(lvl_b); l[2] = int'(lvl_c);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d.data_out@%0d", k, ecyc), 64'(d[k]), 64'(cur[k]));
      chk($sformatf("u%0d.data_updated@%0d", k, ecyc), 64'(u[k]), 64'(mupd[k]));
      chk($sformatf("u%0d.fifo_level@%0d", k, ecyc), 64'(l[k]), 64'(mfifo[k].size()));
      if (u[k] === 1'b1) log_q[k].push_back('{ecyc, d[k]});
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_update(k);
    ecyc++;
    @(negedge clk);
    compare_all();
  endtask

  task automatic push_ch(input int k, input logic [15:0] v);
    multisim_chan_pkg::chan[k].push_back(64'(v));
    pend[k].push_back(v);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) model_rst(k);
    #1;
    compare_all();
    repeat (n) cycle();
    rst = 1'b0;
  endtask

  initial begin
    multisim_chan_pkg::chan_name[0] = "qs_a";
    multisim_chan_pkg::chan_name[1] = "qs_b";
    multisim_chan_pkg::chan_name[2] = "qs_c";
    dep[0] = 3; dep[1] = 4; dep[2] = 4;
    hld[0] = 2; hld[1] = 0; hld[2] = 10;
    for (int k = 0; k < 3; k++) begin
      offered[k] = 1'b0;
      model_rst(k);
    end
    rst = 1'b1;

    // Reset: three cycles, release with no traffic, ready rises only after the first edge.
    repeat (3) cycle();
    rst = 1'b0;
    #1;
    chk("rdy_before_first_edge", 64'(u_a.data_rdy), 64'd0);
    cycle();
    chk("rdy_after_first_edge", 64'(u_a.data_rdy), 64'd1);
    repeat (3) cycle();

    // Vector table on the zero-hold instance: latency, back-to-back, repeated value.
    tbl[0]  = '{1'b1, 16'h0005, 16'hDEAD, 1'b0, 0};
    tbl[1]  = '{1'b0, 16'h0000, 16'hDEAD, 1'b0, 1};
    tbl[2]  = '{1'b0, 16'h0000, 16'h0005, 1'b1, 0};
    tbl[3]  = '{1'b0, 16'h0000, 16'h0005, 1'b0, 0};
    tbl[4]  = '{1'b1, 16'h0011, 16'h0005, 1'b0, 0};
    tbl[5]  = '{1'b1, 16'h0022, 16'h0005, 1'b0, 1};
    tbl[6]  = '{1'b0, 16'h0000, 16'h0011, 1'b1, 1};
    tbl[7]  = '{1'b0, 16'h0000, 16'h0022, 1'b1, 0};
    tbl[8]  = '{1'b0, 16'h0000, 16'h0022, 1'b0, 0};
    tbl[9]  = '{1'b1, 16'h0022, 16'h0022, 1'b0, 0};
    tbl[10] = '{1'b0, 16'h0000, 16'h0022, 1'b0, 1};
    tbl[11] = '{1'b0, 16'h0000, 16'h0022, !FILT, 0};
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].push) push_ch(1, tbl[i].val);
      cycle();
      chk($sformatf("tbl[%0d].data_out", i), 64'(dout_b), 64'(tbl[i].exp_out));
      chk($sformatf("tbl[%0d].data_updated", i), 64'(upd_b), 64'(tbl[i].exp_upd));
      chk($sformatf("tbl[%0d].fifo_level", i), 64'(lvl_b), 64'(tbl[i].exp_lvl));
    end

    // Burst of four with hold 2: one step every 3 cycles.
    log_q[0].delete();
    for (int i = 1; i <= 4; i++) push_ch(0, 16'(i));
    repeat (20) cycle();
    chk("burst_pulses", 64'(log_q[0].size()), 64'd4);
    for (int i = 0; i < log_q[0].size(); i++) begin
      chk($sformatf("burst_val[%0d]", i), 64'(log_q[0][i].v), 64'(i + 1));
      if (i > 0) chk($sformatf("burst_gap[%0d]", i), 64'(log_q[0][i].cyc - log_q[0][i-1].cyc), 64'd3);
    end

    // Repeated value: the filter suppresses the second 'h9.
    log_q[0].delete();
    push_ch(0, 16'h9); push_ch(0, 16'h9); push_ch(0, 16'hA);
    repeat (20) cycle();
    chk("dup_pulses", 64'(log_q[0].size()), FILT ? 64'd2 : 64'd3);

    // Full FIFO with long hold: four buffered, ready low, nothing lost.
    log_q[2].delete();
    for (int i = 0; i < 6; i++) push_ch(2, 16'h100 + 16'(i));
    repeat (8) cycle();
    chk("full_level", 64'(lvl_c), 64'd4);
    chk("full_rdy_low", 64'(u_c.data_rdy), 64'd0);
    repeat (75) cycle();
    chk("full_pulses", 64'(log_q[2].size()), 64'd6);
    for (int i = 0; i < log_q[2].size(); i++) begin
      chk($sformatf("full_val[%0d]", i), 64'(log_q[2][i].v), 64'(16'h100 + 16'(i)));
      if (i > 0) chk($sformatf("full_gap[%0d]", i), 64'(log_q[2][i].cyc - log_q[2][i-1].cyc), 64'd11);
    end

    // Mid-stream reset with three buffered entries.
    for (int i = 0; i < 4; i++) push_ch(0, 16'h31 + 16'(i));
    for (int i = 0; i < 10 && lvl_a != 2'd3; i++) cycle();
    chk("midrst_fill", 64'(lvl_a), 64'd3);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) model_rst(k);
    #1;
    chk("midrst_async_out", 64'(dout_a), 64'hDEAD);
    chk("midrst_async_lvl", 64'(lvl_a), 64'd0);
    cycle();
    rst = 1'b0;
    push_ch(0, 16'h7);
    repeat (2) cycle();
    chk("midrst_not_yet", 64'(dout_a), 64'hDEAD);
    cycle();
    chk("midrst_new_val", 64'(dout_a), 64'h7);
    chk("midrst_new_upd", 64'(upd_a), 64'd1);
    repeat (4) cycle();

    // Random traffic against the model, with one reset while backlog is pending.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset(1);
      for (int k = 0; k < 3; k++)
        if ($urandom_range(0, (k == 2) ? 15 : 3) == 0) push_ch(k, 16'h40 + 16'($urandom_range(0, 3)));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
